// File: rtl/image_load_block_if.sv
// Bundle of the layer-load request/response signals and the feature-map RAM read port.
// The load block sits on the slave side; the requesting layer plus RAM sit on the master side.
interface image_load_block_if #(
  parameter int DATA_SZ   = 16,
  parameter int ADDR_SZ   = 16,
  parameter int BUF_DEPTH = 1024
);
  logic                      loadEnable;
  logic [ADDR_SZ-1:0]        loadAddr;
  logic [DATA_SZ-1:0]        loadSize;
  logic signed [DATA_SZ-1:0] loadOut [BUF_DEPTH];
  logic                      loadDone;
  logic                      loadErr;
  logic                      memRdEn;
  logic [ADDR_SZ-1:0]        memAddr;
  logic [DATA_SZ-1:0]        memData;

  modport slave (
    input  loadEnable, loadAddr, loadSize, memData,
    output loadOut, loadDone, loadErr, memRdEn, memAddr
  );

  modport master (
    output loadEnable, loadAddr, loadSize, memData,
    input  loadOut, loadDone, loadErr, memRdEn, memAddr
  );
endinterface

// File: rtl/image_load_block.sv
// Copies a loadSize x loadSize image from the feature-map RAM into a local buffer
// and presents it to the pool/conv layer, with one request outstanding at a time.
module image_load_block #(
  parameter int DATA_SZ   = 16,
  parameter int ADDR_SZ   = 16,
  parameter int BUF_DEPTH = 1024
) (
  input  logic               clk,
  input  logic               reset,
  image_load_block_if.slave  bus
);
  localparam int IDX_W  = $clog2(BUF_DEPTH) + 1;
  localparam int PROD_W = 2 * DATA_SZ;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [ADDR_SZ-1:0]        r_base;
  logic [ADDR_SZ-1:0]        r_memAddr;
  logic [IDX_W-1:0]          r_count;
  logic [IDX_W-1:0]          r_rdIdx;
  logic [IDX_W-1:0]          r_wrIdx;
  logic                      r_memRdEn;
  logic                      r_dataValid;
  logic                      r_loadDone;
  logic                      r_loadErr;
  logic signed [DATA_SZ-1:0] r_buf [BUF_DEPTH];

  logic [PROD_W-1:0]         w_product;
  logic                      w_tooBig;
  logic [IDX_W-1:0]          w_count;
  logic                      w_accept;
  logic                      w_issue;
  logic                      w_capture;

  // Full-width square so large sizes cannot wrap below the buffer limit.
  assign w_product = PROD_W'(bus.loadSize) * PROD_W'(bus.loadSize);
  assign w_tooBig  = w_product > PROD_W'(BUF_DEPTH);
  assign w_count   = w_tooBig ? IDX_W'(BUF_DEPTH) : w_product[IDX_W-1:0];

  assign bus.loadOut  = r_buf;
  assign bus.loadDone = r_loadDone;
  assign bus.loadErr  = r_loadErr;
  assign bus.memRdEn  = r_memRdEn;
  assign bus.memAddr  = r_memAddr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Dropping loadEnable anywhere but IDLE returns to IDLE; in-flight data is then ignored.
  always_comb begin
    w_next    = r_state;
    w_accept  = (r_state == IDLE) && bus.loadEnable;
    w_issue   = (r_state == FETCH) && bus.loadEnable;
    w_capture = r_dataValid && bus.loadEnable &&
                ((r_state == FETCH) || (r_state == DRAIN));
    case (r_state)
      IDLE: begin
        if (bus.loadEnable) w_next = (w_count == '0) ? DONE : FETCH;
      end
      FETCH: begin
        if (!bus.loadEnable)                     w_next = IDLE;
        else if (r_rdIdx == r_count - IDX_W'(1)) w_next = DRAIN;
      end
      DRAIN: begin
        if (!bus.loadEnable)                                   w_next = IDLE;
        else if (w_capture && (r_wrIdx == r_count - IDX_W'(1))) w_next = DONE;
      end
      DONE: begin
        if (!bus.loadEnable) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_memAddr   <= '0;
      r_count     <= '0;
      r_rdIdx     <= '0;
      r_wrIdx     <= '0;
      r_memRdEn   <= 1'b0;
      r_dataValid <= 1'b0;
      r_loadDone  <= 1'b0;
      r_loadErr   <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_memRdEn   <= w_issue;
      r_dataValid <= r_memRdEn;
      // An empty image goes straight to DONE, so loadDone rises one edge later.
      r_loadDone  <= (w_next == DONE) && (r_state != IDLE);

      if (w_issue) begin
        r_memAddr <= r_base + ADDR_SZ'(r_rdIdx);
        r_rdIdx   <= r_rdIdx + IDX_W'(1);
      end

      if (w_accept) begin
        r_base    <= bus.loadAddr;
        r_count   <= w_count;
        r_loadErr <= w_tooBig;
        r_rdIdx   <= '0;
        r_wrIdx   <= '0;
        for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
      end else begin
        if (w_next == IDLE) r_loadErr <= 1'b0;
        if (w_capture) begin
          r_buf[r_wrIdx[IDX_W-2:0]] <= $signed(bus.memData);
          r_wrIdx                   <= r_wrIdx + IDX_W'(1);
        end
      end
    end
  end
endmodule
